mem_arbiter: RTL and testbench

Two-port arbiter that shares the single memory bus between the instruction-fetch path and the data load/store path of the RV32I core. It sits between the fetch/LSU requesters and the bus-side memory interface. It serialises one transaction at a time, holds the request while the bus reports full, and waits for the bus response. It returns read data and a one-cycle acknowledge to the winning requester. Data accesses have priority, and a streak counter bounds instruction-fetch starvation.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default limits for the fetch/LSU memory-bus arbiter.
package mem_arb_pkg;

   localparam int ARB_STARVE_MAX = 4;
   localparam int ARB_TIMEOUT    = 255;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP, ARB_DONE} arb_state_t;
   typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;
   typedef enum logic {OP_READ, OP_WRITE} op_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision: data has priority unless instruction fetch has waited
// through STARVE_MAX consecutive data grants.
module mem_arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = ARB_STARVE_MAX,
   parameter int STREAK_W   = $clog2(ARB_STARVE_MAX + 1)
) (
   input  logic                instr_req,
   input  logic                data_read,
   input  logic                data_write,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant_valid,
   output logic                grant_data,
   output logic                grant_write
);

   logic data_req;
   logic instr_turn;

   always_comb begin
      data_req    = data_read | data_write;
      instr_turn  = instr_req & (~data_req | (streak == STREAK_W'(STARVE_MAX)));
      grant_valid = instr_req | data_req;
      grant_data  = data_req & ~instr_turn;
      // read and write together are served as a read
      grant_write = grant_data & data_write & ~data_read;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store transactions onto one memory bus,
// one outstanding transaction at a time, with a response timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = ARB_STARVE_MAX,
   parameter int TIMEOUT    = ARB_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_ack,
   output logic [31:0] instr_rdata,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_ack,
   output logic [31:0] data_rdata,
   input  logic        bus_full,
   input  logic        bus_valid,
   input  logic [31:0] bus_rdata,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_err,
   output logic        busy
);

   localparam int STREAK_W = $clog2(STARVE_MAX + 1);
   localparam int TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STARVE_MAX);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);

   arb_state_t          state_reg, state_next;
   owner_t              owner_reg, owner_next;
   op_t                 op_reg, op_next;
   logic                err_reg, err_next;
   logic [STREAK_W-1:0] streak_reg, streak_next;
   logic [TMO_W-1:0]    tmo_cnt_reg, tmo_cnt_next;
   logic [31:0]         bus_addr_reg, bus_addr_next;
   logic [31:0]         bus_wdata_reg, bus_wdata_next;
   logic [31:0]         instr_rdata_reg, instr_rdata_next;
   logic [31:0]         data_rdata_reg, data_rdata_next;

   logic                grant_valid, grant_data, grant_write;
   logic                capture_en;
   logic [31:0]         capture_word;

   mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .STREAK_W   (STREAK_W)
   ) u_pick (
      .instr_req   (instr_req),
      .data_read   (data_read),
      .data_write  (data_write),
      .streak      (streak_reg),
      .grant_valid (grant_valid),
      .grant_data  (grant_data),
      .grant_write (grant_write)
   );

   always_comb begin
      state_next       = state_reg;
      owner_next       = owner_reg;
      op_next          = op_reg;
      err_next         = err_reg;
      streak_next      = streak_reg;
      tmo_cnt_next     = tmo_cnt_reg;
      bus_addr_next    = bus_addr_reg;
      bus_wdata_next   = bus_wdata_reg;
      instr_rdata_next = instr_rdata_reg;
      data_rdata_next  = data_rdata_reg;
      capture_en       = 1'b0;
      capture_word     = '0;

      case (state_reg)
         ARB_IDLE: begin
            if (grant_valid) begin
               state_next     = ARB_ISSUE;
               owner_next     = grant_data ? OWN_DATA : OWN_INSTR;
               op_next        = grant_write ? OP_WRITE : OP_READ;
               bus_addr_next  = grant_data ? data_addr : instr_addr;
               bus_wdata_next = grant_data ? data_wdata : '0;
               // only data grants that bypass a waiting fetch extend the streak
               if (grant_data && instr_req)
                  streak_next = (streak_reg == STREAK_TOP) ? streak_reg
                                                           : streak_reg + STREAK_W'(1);
               else
                  streak_next = '0;
            end
         end
         ARB_ISSUE: begin
            if (!bus_full) begin
               state_next   = ARB_RESP;
               tmo_cnt_next = '0;
            end
         end
         ARB_RESP: begin
            if (bus_valid) begin
               capture_en   = 1'b1;
               capture_word = (op_reg == OP_WRITE) ? '0 : bus_rdata;
               state_next   = ARB_DONE;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               capture_en = 1'b1;
               err_next   = 1'b1;
               state_next = ARB_DONE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end
         ARB_DONE: begin
            state_next = ARB_IDLE;
            err_next   = 1'b0;
         end
         default: state_next = ARB_IDLE;
      endcase

      if (capture_en) begin
         if (owner_reg == OWN_DATA) data_rdata_next  = capture_word;
         else                       instr_rdata_next = capture_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ARB_IDLE;
         owner_reg       <= OWN_INSTR;
         op_reg          <= OP_READ;
         err_reg         <= 1'b0;
         streak_reg      <= '0;
         tmo_cnt_reg     <= '0;
         bus_addr_reg    <= '0;
         bus_wdata_reg   <= '0;
         instr_rdata_reg <= '0;
         data_rdata_reg  <= '0;
      end else begin
         state_reg       <= state_next;
         owner_reg       <= owner_next;
         op_reg          <= op_next;
         err_reg         <= err_next;
         streak_reg      <= streak_next;
         tmo_cnt_reg     <= tmo_cnt_next;
         bus_addr_reg    <= bus_addr_next;
         bus_wdata_reg   <= bus_wdata_next;
         instr_rdata_reg <= instr_rdata_next;
         data_rdata_reg  <= data_rdata_next;
      end
   end

   assign bus_read    = (state_reg == ARB_ISSUE) & ~bus_full & (op_reg == OP_READ);
   assign bus_write   = (state_reg == ARB_ISSUE) & ~bus_full & (op_reg == OP_WRITE);
   assign instr_ack   = (state_reg == ARB_DONE) & (owner_reg == OWN_INSTR);
   assign data_ack    = (state_reg == ARB_DONE) & (owner_reg == OWN_DATA);
   assign bus_err     = (state_reg == ARB_DONE) & err_reg;
   assign busy        = (state_reg != ARB_IDLE);
   assign bus_addr    = bus_addr_reg;
   assign bus_wdata   = bus_wdata_reg;
   assign instr_rdata = instr_rdata_reg;
   assign data_rdata  = data_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation/reset sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int STARVE = 4;
   localparam int TMO    = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_ack;
   logic [31:0] instr_rdata;
   logic        data_read, data_write;
   logic [31:0] data_addr, data_wdata;
   logic        data_ack;
   logic [31:0] data_rdata;
   logic        bus_full, bus_valid;
   logic [31:0] bus_rdata;
   logic        bus_read, bus_write;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_err, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_ack(instr_ack), .instr_rdata(instr_rdata),
      .data_read(data_read), .data_write(data_write),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_ack(data_ack), .data_rdata(data_rdata),
      .bus_full(bus_full), .bus_valid(bus_valid), .bus_rdata(bus_rdata),
      .bus_read(bus_read), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_err(bus_err), .busy(busy)
   );

   typedef struct {
      int          strobe;
      int          ack;
      int          nstrobe;
      int          nidle;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        ack_i;
      logic        ack_d;
      logic        err;
      logic [31:0] irdata;
      logic [31:0] drdata;
   } res_t;

   typedef struct {
      logic        ir, dr, dw;
      logic [31:0] ia, da, wd, rd;
      int          nfull, ndelay;
      logic        e_data, e_wr;
      logic [31:0] e_addr, e_rdata;
      int          e_strobe, e_ack;
      logic        e_err;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   // reference copies of the registered rdata ports
   logic [31:0] m_ird, m_drd;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic set_req(input logic ir, input logic dr, input logic dw,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
      instr_req = ir; data_read = dr; data_write = dw;
      instr_addr = ia; data_addr = da; data_wdata = wd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
      bus_full = 1'b0; bus_valid = 1'b0; bus_rdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_ird = '0;
      m_drd = '0;
   endtask

   // Acts as the bus slave. Entered 1 ns after an edge; the next edge is the
   // IDLE sampling edge N, and loop index k counts cycles N+k.
   task automatic run_txn(input int nfull, input int ndelay, input logic [31:0] rd, output res_t r);
      r.strobe = -1; r.ack = -1; r.nstrobe = 0; r.nidle = 0; r.wr = 1'b0;
      r.addr = '0; r.wdata = '0; r.ack_i = 1'b0; r.ack_d = 1'b0; r.err = 1'b0;
      r.irdata = '0; r.drdata = '0;
      for (int k = 1; k <= 600; k++) begin
         @(posedge clk); #1;
         bus_full  = (k <= nfull);
         bus_valid = (r.strobe > 0) && (ndelay >= 0) && (k == r.strobe + 1 + ndelay);
         bus_rdata = bus_valid ? rd : $urandom();
         @(negedge clk);
         if (!busy) r.nidle++;
         if (bus_read || bus_write) begin
            r.nstrobe++;
            r.strobe = k;
            r.wr     = bus_write;
            r.addr   = bus_addr;
            r.wdata  = bus_wdata;
         end
         if (instr_ack || data_ack) begin
            r.ack    = k;
            r.ack_i  = instr_ack;
            r.ack_d  = data_ack;
            r.err    = bus_err;
            r.irdata = instr_rdata;
            r.drdata = data_rdata;
            break;
         end
      end
      bus_full  = 1'b0;
      bus_valid = 1'b0;
      if (r.ack < 0) check1("txn_ack_within_bound", 1'b0, 1'b1);
   endtask

   task automatic verify(input string tag, input res_t r, input logic e_data, input logic e_wr,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata, input int e_strobe, input int e_ack,
                         input logic e_err);
      if (e_data) m_drd = e_rdata;
      else        m_ird = e_rdata;
      check32({tag, "_strobe_cycle"}, r.strobe, e_strobe);
      check32({tag, "_strobe_count"}, r.nstrobe, 1);
      check1({tag, "_is_write"}, r.wr, e_wr);
      check32({tag, "_bus_addr"}, r.addr, e_addr);
      if (e_wr) check32({tag, "_bus_wdata"}, r.wdata, e_wdata);
      check32({tag, "_ack_cycle"}, r.ack, e_ack);
      check1({tag, "_data_ack"}, r.ack_d, e_data);
      check1({tag, "_instr_ack"}, r.ack_i, ~e_data);
      check1({tag, "_bus_err"}, r.err, e_err);
      check32({tag, "_instr_rdata"}, r.irdata, m_ird);
      check32({tag, "_data_rdata"}, r.drdata, m_drd);
      check32({tag, "_idle_cycles"}, r.nidle, 0);
      $display("txn %s: strobe@%0d ack@%0d addr=0x%08h instr_ack=%0b data_ack=%0b err=%0b",
               tag, r.strobe, r.ack, r.addr, r.ack_i, r.ack_d, r.err);
   endtask

   vec_t tbl[7];

   initial begin
      res_t  r;
      string seq;
      int    dstreak;
      logic  ir, dr, dw, win_data, wr;
      logic [31:0] ia, da, wd, rd;
      int    nfull, ndelay;

      do_reset();
      rst = 1'b1;
      @(negedge clk);
      check1("reset_busy", busy, 1'b0);
      check1("reset_instr_ack", instr_ack, 1'b0);
      check1("reset_data_ack", data_ack, 1'b0);
      check1("reset_bus_read", bus_read, 1'b0);
      check1("reset_bus_write", bus_write, 1'b0);
      check1("reset_bus_err", bus_err, 1'b0);
      check32("reset_bus_addr", bus_addr, '0);
      check32("reset_bus_wdata", bus_wdata, '0);
      check32("reset_instr_rdata", instr_rdata, '0);
      check32("reset_data_rdata", data_rdata, '0);
      do_reset();

      // ir dr dw  ia  da  wd  rd  nfull ndelay | e_data e_wr e_addr e_rdata e_strobe e_ack e_err
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h13, 0, 0,
                 1'b0, 1'b0, 32'h40, 32'h13, 1, 3, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'h1000, 32'hDEADBEEF, 32'h5A5A, 0, 0,
                 1'b1, 1'b1, 32'h1000, 32'h0, 1, 3, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 32'h17, 0, 0,
                 1'b0, 1'b0, 32'h44, 32'h17, 1, 3, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h2000, 32'h0, 32'hCAFEF00D, 3, 0,
                 1'b1, 1'b0, 32'h2000, 32'hCAFEF00D, 4, 6, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h3000, 32'h1234, 32'h55AA, 0, 2,
                 1'b1, 1'b0, 32'h3000, 32'h55AA, 1, 5, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 32'h0BAD, 0, -1,
                 1'b0, 1'b0, 32'h80, 32'h0, 1, TMO + 2, 1'b1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 32'h99, 1, 1,
                 1'b1, 1'b0, 32'h10, 32'h99, 2, 5, 1'b0};

      for (int i = 0; i < 7; i++) begin
         set_req(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da, tbl[i].wd);
         run_txn(tbl[i].nfull, tbl[i].ndelay, tbl[i].rd, r);
         verify($sformatf("vec%0d", i), r, tbl[i].e_data, tbl[i].e_wr, tbl[i].e_addr,
                tbl[i].wd, tbl[i].e_rdata, tbl[i].e_strobe, tbl[i].e_ack, tbl[i].e_err);
         @(posedge clk); #1;
      end

      // Both requesters held continuously: fetch gets every fifth grant.
      do_reset();
      seq = "DDDDIDDDDI";
      set_req(1'b1, 1'b1, 1'b0, 32'h400, 32'h800, 32'h0);
      for (int i = 0; i < 10; i++) begin
         run_txn(0, 0, 32'h100 + i, r);
         verify($sformatf("starve%0d", i), r, seq[i] == 8'h44, 1'b0,
                (seq[i] == 8'h44) ? 32'h800 : 32'h400, 32'h0, 32'h100 + i, 1, 3, 1'b0);
         @(posedge clk); #1;
      end

      // Reset while waiting in RESP; the late response must be discarded.
      set_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check1("rstmid_strobe", bus_read, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
      bus_valid = 1'b1;
      bus_rdata = 32'h777;
      @(negedge clk);
      check1("rstmid_busy", busy, 1'b0);
      check1("rstmid_instr_ack", instr_ack, 1'b0);
      check1("rstmid_bus_read", bus_read, 1'b0);
      check32("rstmid_instr_rdata", instr_rdata, '0);
      check32("rstmid_bus_addr", bus_addr, '0);
      @(posedge clk); #1;
      bus_valid = 1'b0;
      @(negedge clk);
      check1("rstmid_no_late_ack", instr_ack | data_ack, 1'b0);
      m_ird = '0;
      m_drd = '0;
      @(posedge clk); #1;
      set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0);
      run_txn(0, 0, 32'h2222, r);
      verify("after_rst", r, 1'b1, 1'b0, 32'h200, 32'h0, 32'h2222, 1, 3, 1'b0);
      @(posedge clk); #1;

      // Randomized traffic against a transaction-level model: data goes first
      // unless the fetch has already been passed over STARVE times in a row.
      do_reset();
      dstreak = 0;
      for (int i = 0; i < 60; i++) begin
         {ir, dr, dw} = 3'($urandom_range(1, 7));
         ia = $urandom(); da = $urandom(); wd = $urandom(); rd = $urandom();
         nfull  = $urandom_range(0, 3);
         ndelay = $urandom_range(0, 4);
         win_data = (dr | dw) && !(ir && dstreak >= STARVE);
         if (win_data && ir) dstreak = (dstreak < STARVE) ? dstreak + 1 : STARVE;
         else                dstreak = 0;
         wr = win_data && dw && !dr;
         set_req(ir, dr, dw, ia, da, wd);
         run_txn(nfull, ndelay, rd, r);
         verify($sformatf("rnd%0d", i), r, win_data, wr, win_data ? da : ia, wd,
                wr ? 32'h0 : rd, 1 + nfull, 3 + nfull + ndelay, 1'b0);
         @(posedge clk); #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
